// File: rtl/char_render_ctrl.sv
// Glyph renderer: fetches an 8x8 bitmap from charmem and streams 64 pixel writes to the framebuffer.
// Optional build macro CHAR_TRANSPARENT_EN: 0 bits produce no write and take one cycle each.
module char_render_ctrl #(
    parameter int NUM_CHARS = 40,
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int COLOR_W   = 8,
    parameter int ADDR_W    = 19,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         req_char,
    input  logic [6:0]         req_col,
    input  logic [5:0]         req_row,
    input  logic [COLOR_W-1:0] req_color,
    output logic               charprint,
    output logic [5:0]         caractere,
    input  logic [63:0]        bitmap,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [5:0]        CHAR_LIM   = 6'(NUM_CHARS);
    localparam logic [6:0]        COL_LIM    = 7'(COLS);
    localparam logic [5:0]        ROW_LIM    = 6'(ROWS);
    localparam logic [ADDR_W-1:0] LINE_PITCH = ADDR_W'(COLS * 8);

    state_t               state_q, state_d;
    logic [5:0]           char_q, char_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 err_q, err_d;
    logic [63:0]          bmp_q, bmp_d;
    logic [2:0]           x_q, x_d;
    logic [2:0]           y_q, y_d;

    logic                 illegal;
    logic                 advance;
    logic [5:0]           pix_idx;
    logic                 pix_bit;
    logic [ADDR_W-1:0]    pix_addr;

    assign illegal = (req_char >= CHAR_LIM) || (req_col >= COL_LIM) || (req_row >= ROW_LIM);

    // 63-(y*8+x) on six bits is the bitwise complement: MSB is the top-left pixel.
    assign pix_idx  = ~{y_q, x_q};
    assign pix_bit  = bmp_q[pix_idx];
    assign pix_addr = base_q + ADDR_W'(y_q) * LINE_PITCH + ADDR_W'(x_q);

    assign req_ready = rst_n && (state_q == S_IDLE);
    assign caractere = (state_q == S_FETCH) ? char_q : 6'd0;
    assign fb_addr   = (state_q == S_DRAW) ? pix_addr : '0;
    assign fb_data   = (state_q == S_DRAW) ? (pix_bit ? color_q : BG_COLOR) : '0;

    always_comb begin
        state_d   = state_q;
        char_d    = char_q;
        color_d   = color_q;
        base_d    = base_q;
        err_d     = err_q;
        bmp_d     = bmp_q;
        x_d       = x_q;
        y_d       = y_q;
        charprint = 1'b0;
        fb_we     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        advance   = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    char_d  = req_char;
                    color_d = req_color;
                    base_d  = (ADDR_W'(req_row) << 3) * LINE_PITCH + (ADDR_W'(req_col) << 3);
                    err_d   = illegal;
                    state_d = illegal ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                charprint = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                bmp_d   = bitmap;
                x_d     = 3'd0;
                y_d     = 3'd0;
                state_d = S_DRAW;
            end
            S_DRAW: begin
`ifdef CHAR_TRANSPARENT_EN
                fb_we   = pix_bit;
                advance = !pix_bit || fb_ready;
`else
                fb_we   = 1'b1;
                advance = fb_ready;
`endif
                if (advance) begin
                    x_d = x_q + 3'd1;
                    if (x_q == 3'd7) begin
                        y_d = y_q + 3'd1;
                    end
                    if ({y_q, x_q} == 6'd63) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            char_q  <= '0;
            color_q <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
            bmp_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            color_q <= color_d;
            base_q  <= base_d;
            err_q   <= err_d;
            bmp_q   <= bmp_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_char_render_ctrl.sv
// Scoreboard bench for char_render_ctrl: stimulus pushes expected writes/fetches/dones, a monitor pops and checks.
module tb_char_render_ctrl;

    localparam int COLOR_W = 8;
    localparam int ADDR_W  = 19;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [5:0]         req_char = '0;
    logic [6:0]         req_col = '0;
    logic [5:0]         req_row = '0;
    logic [COLOR_W-1:0] req_color = '0;
    logic               charprint;
    logic [5:0]         caractere;
    logic [63:0]        bitmap = '0;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_ready = 1'b1;
    logic               busy;
    logic               done;
    logic               err;

    char_render_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_char  (req_char),
        .req_col   (req_col),
        .req_row   (req_row),
        .req_color (req_color),
        .charprint (charprint),
        .caractere (caractere),
        .bitmap    (bitmap),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_ready  (fb_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]  a;
        logic [COLOR_W-1:0] d;
    } wr_t;
    typedef struct {
        int         c;
        logic [5:0] ch;
    } cp_t;
    typedef struct {
        int   c;
        logic e;
    } dn_t;

    wr_t wq[$];
    cp_t cq[$];
    dn_t dq[$];
    logic [ADDR_W-1:0] fg[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur_fire = -100;
    bit cur_bp = 1'b0;
    logic [63:0] cur_bmp = '0;
    int last_done = 0;
    logic last_err = 1'b0;
    int wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Charmem and framebuffer-ready models: bitmap is only meaningful in the WAIT cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bitmap   = (cyc == cur_fire + 2) ? cur_bmp : (~cur_bmp ^ 64'h5A5A_A5A5_0F0F_F0F0);
            fb_ready = cur_bp ? (((cyc - cur_fire) % 2) == 1) : 1'b1;
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fb_we) begin
                    total++;
                    if (wq.size() == 0) begin
                        bad++;
                        $display("FAIL wr_unexpected got addr=%0d data=%0h want none", fb_addr, fb_data);
                    end else begin
                        if (fb_addr !== wq[0].a || fb_data !== wq[0].d) begin
                            bad++;
                            $display("FAIL wr got addr=%0d data=%0h want addr=%0d data=%0h",
                                     fb_addr, fb_data, wq[0].a, wq[0].d);
                        end
                        if (fb_ready) void'(wq.pop_front());
                    end
                    if (fb_ready) begin
                        wr_cnt++;
                        if (fb_data == 8'hA5) fg.push_back(fb_addr);
                    end
                end
                if (charprint) begin
                    total++;
                    if (cq.size() == 0) begin
                        bad++;
                        $display("FAIL fetch_unexpected got cyc=%0d char=%0d want none", cyc, caractere);
                    end else begin
                        if (cyc != cq[0].c || caractere !== cq[0].ch) begin
                            bad++;
                            $display("FAIL fetch got cyc=%0d char=%0d want cyc=%0d char=%0d",
                                     cyc, caractere, cq[0].c, cq[0].ch);
                        end
                        void'(cq.pop_front());
                    end
                end
                if (err && !done) begin
                    total++;
                    bad++;
                    $display("FAIL err_alone got err=1 done=0 want err only with done");
                end
                if (done) begin
                    total++;
                    last_done = cyc;
                    last_err  = err;
                    $display("done cyc=%0d err=%0b", cyc, err);
                    if (dq.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected got cyc=%0d want none", cyc);
                    end else begin
                        if (cyc != dq[0].c || err !== dq[0].e) begin
                            bad++;
                            $display("FAIL done got cyc=%0d err=%0b want cyc=%0d err=%0b",
                                     cyc, err, dq[0].c, dq[0].e);
                        end
                        void'(dq.pop_front());
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic bit rdy_at(input bit bp, input int t);
        return bp ? ((t % 2) == 1) : 1'b1;
    endfunction

    task automatic issue(input logic [5:0] ch, input logic [6:0] col, input logic [5:0] row,
                         input logic [7:0] color, input logic [63:0] bmp,
                         input bit bp, input bit keep, output int f);
        int  n;
        int  t;
        bit  b;
        wr_t w;
        cp_t c;
        dn_t d;
        req_char  = ch;
        req_col   = col;
        req_row   = row;
        req_color = color;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_valid && req_ready) && n < 400);
        if (!(req_valid && req_ready)) begin
            total++;
            bad++;
            $display("FAIL fire_timeout got ready=0 want ready=1");
            req_valid = 1'b0;
            f = -1;
            return;
        end
        f = cyc;
        cur_fire = f;
        cur_bp   = bp;
        cur_bmp  = bmp;
        if (ch < 40 && col < 80 && row < 60) begin
            c.c = f + 1;
            c.ch = ch;
            cq.push_back(c);
            t = 3;
            for (int y = 0; y < 8; y++) begin
                for (int x = 0; x < 8; x++) begin
                    b = bmp[63 - (y * 8 + x)];
`ifdef CHAR_TRANSPARENT_EN
                    if (!b) begin
                        t++;
                        continue;
                    end
`endif
                    w.a = ADDR_W'((int'(row) * 8 + y) * 640 + int'(col) * 8 + x);
                    w.d = b ? color : 8'h00;
                    wq.push_back(w);
                    while (!rdy_at(bp, t)) t++;
                    t++;
                end
            end
            d.c = f + t;
            d.e = 1'b0;
        end else begin
            d.c = f + 1;
            d.e = 1'b1;
        end
        dq.push_back(d);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((dq.size() != 0 || wq.size() != 0 || cq.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (dq.size() != 0 || wq.size() != 0 || cq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want 0", dq.size() + wq.size() + cq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f;
        int f2;

        // Reset with a pending request
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_charprint", charprint, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_caractere", caractere, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        req_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_req_ready", req_ready, 1);
        chk("rel_busy", busy, 0);

        // Legal draw
        fg.delete();
        issue(6'd5, 7'd2, 6'd1, 8'hA5, 64'h8000_0000_0000_0001, 1'b0, 1'b0, f);
        drain();
        chk("t2_latency", last_done - f, 67);
        chk("t2_fg_count", fg.size(), 2);
        if (fg.size() == 2) begin
            chk("t2_fg_first", fg[0], 5136);
            chk("t2_fg_last", fg[1], 9623);
        end

        // Backpressure
        issue(6'd5, 7'd2, 6'd1, 8'hA5, 64'h8000_0000_0000_0001, 1'b1, 1'b0, f);
        drain();
`ifdef CHAR_TRANSPARENT_EN
        chk("t3_latency", last_done - f, 68);
`else
        chk("t3_latency", last_done - f, 130);
`endif

        // Illegal requests
        issue(6'd40, 7'd0, 6'd0, 8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, f);
        drain();
        chk("t4_char_latency", last_done - f, 1);
        chk("t4_char_err", last_err, 1);
        issue(6'd0, 7'd80, 6'd0, 8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, f);
        drain();
        chk("t4_col_latency", last_done - f, 1);
        issue(6'd0, 7'd0, 6'd60, 8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, f);
        drain();
        chk("t4_row_latency", last_done - f, 1);
        chk("t4_row_err", last_err, 1);

        // Back-to-back with req_valid held; second request at the last legal cell
        issue(6'd3, 7'd0, 6'd0, 8'h3C, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, f);
        issue(6'd39, 7'd79, 6'd59, 8'h77, 64'hF0F0_0F0F_AA55_55AA, 1'b0, 1'b0, f2);
        drain();
        chk("t5_second_fire", f2 - f, 68);
        chk("t5_last_err", last_err, 0);

        // Low byte only: bottom glyph row
        wr_cnt = 0;
        issue(6'd1, 7'd0, 6'd0, 8'hC3, 64'h0000_0000_0000_00FF, 1'b0, 1'b0, f);
        drain();
        chk("t6_latency", last_done - f, 67);
`ifdef CHAR_TRANSPARENT_EN
        chk("t6_writes", wr_cnt, 8);
`else
        chk("t6_writes", wr_cnt, 64);
`endif

        // Reset mid-draw: no done pulse afterwards
        issue(6'd2, 7'd10, 6'd10, 8'h5C, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, f);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_fb_we", fb_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        wq.delete();
        cq.delete();
        dq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("mid_rst_idle_ready", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
